// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: 1K-word RAM plus memory-mapped cycle counter, LED register
// and a transmit FIFO, all read back through a single registered read port.
module dmem_mmio_responder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] leds
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_CYCLE  = 32'h0000_1000;
    localparam logic [31:0] ADDR_LEDS   = 32'h0000_1001;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_1002;
    localparam logic [31:0] ADDR_TXSTAT = 32'h0000_1003;

    logic [31:0] ram [1024];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    logic [31:0] q_dmem_q, q_dmem_d;
    logic [31:0] cycle_q, cycle_d;
    logic [15:0] leds_q, leds_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic sel_ram, sel_cycle, sel_leds, sel_txdata, sel_txstat;
    logic fifo_empty, fifo_full;
    logic push_req, push, pop, ovf_set, ovf_clr;
    logic [31:0] txstat;

    assign sel_ram    = (address_dmem[31:10] == 22'd0);
    assign sel_cycle  = (address_dmem == ADDR_CYCLE);
    assign sel_leds   = (address_dmem == ADDR_LEDS);
    assign sel_txdata = (address_dmem == ADDR_TXDATA);
    assign sel_txstat = (address_dmem == ADDR_TXSTAT);

    // tx handshake: an entry transfers on a rising edge where tx_valid && tx_ready;
    // tx_valid depends only on registered count, tx_data is held while stalled.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = wren && sel_txdata;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && !push;
    assign ovf_clr    = wren && sel_txstat;

    assign txstat = (32'(count_q) << 3) | {29'd0, overflow_q, fifo_full, fifo_empty};

    always_comb begin
        q_dmem_d = '0;
        if (sel_ram) begin
            q_dmem_d = ram[address_dmem[9:0]];
        end else if (sel_cycle) begin
            q_dmem_d = cycle_q;
        end else if (sel_leds) begin
            q_dmem_d = {16'd0, leds_q};
        end else if (sel_txstat) begin
            q_dmem_d = txstat;
        end
    end

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        leds_d     = leds_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = (overflow_q && !ovf_clr) || ovf_set;
        if (wren && sel_leds) begin
            leds_d = data[15:0];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem_q   <= '0;
            cycle_q    <= '0;
            leds_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            q_dmem_q   <= q_dmem_d;
            cycle_q    <= cycle_d;
            leds_q     <= leds_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage arrays carry no reset: RAM survives reset, FIFO entries are dead once count clears.
    always_ff @(posedge clock) begin
        if (wren && sel_ram) begin
            ram[address_dmem[9:0]] <= data;
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= data;
        end
    end

    assign q_dmem   = q_dmem_q;
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign tx_valid = !fifo_empty;
    assign leds     = leds_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, CYCLE, LEDS, TX FIFO and reset behaviour.
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] leds;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dmem_mmio_responder #(.FIFO_DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .leds         (leds)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] val);
        address_dmem = addr;
        data         = val;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        address_dmem = addr;
        wren         = 1'b0;
        tick();
    endtask

    logic [31:0] v1, v2, v3, prev_data;
    logic        prev_stall;
    logic        wrap_ok;

    initial begin
        reset        = 1'b0;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        tx_ready     = 1'b0;

        // Reset state, before and after clock edges
        #2;
        chk("rst_q_pre_edge", q_dmem, 32'h0);
        chk("rst_txvalid_pre_edge", {31'd0, tx_valid}, 32'h0);
        chk("rst_leds_pre_edge", {16'd0, leds}, 32'h0);
        address_dmem = 32'h1000;
        tick();
        tick();
        chk("rst_q_held", q_dmem, 32'h0);
        reset = 1'b1;

        // CYCLE: first-cycle read is 0, then 10 edges later reads 10
        rd(32'h1000);
        chk("cycle_first", q_dmem, 32'd0);
        repeat (10) tick();
        chk("cycle_plus10", q_dmem, 32'd10);

        // CYCLE wrap via a forced counter value
        force dut.cycle_q = 32'hFFFF_FFFE;
        tick();
        chk("cycle_forced", q_dmem, 32'hFFFF_FFFE);
        release dut.cycle_q;
        tick(); v1 = q_dmem;
        tick(); v2 = q_dmem;
        tick(); v3 = q_dmem;
        wrap_ok = ((v1 == 32'hFFFF_FFFE) && (v2 == 32'hFFFF_FFFF) && (v3 == 32'h0)) ||
                  ((v1 == 32'hFFFF_FFFF) && (v2 == 32'h0) && (v3 == 32'h1));
        chk("cycle_wrap", {31'd0, wrap_ok}, 32'h1);

        // RAM write / read, read-old on same-address write, unmapped reads
        wr(32'h005, 32'hDEAD_BEEF);
        rd(32'h005);
        chk("ram_rd", q_dmem, 32'hDEAD_BEEF);
        wr(32'h005, 32'h1234_5678);
        chk("ram_read_old", q_dmem, 32'hDEAD_BEEF);
        rd(32'h005);
        chk("ram_rd_new", q_dmem, 32'h1234_5678);
        wr(32'h000, 32'h0000_AAAA);
        wr(32'h800, 32'h0000_BBBB);
        rd(32'h800);
        chk("unmapped_800", q_dmem, 32'h0);
        rd(32'h000);
        chk("ram0_not_aliased", q_dmem, 32'h0000_AAAA);
        rd(32'h1004);
        chk("unmapped_1004", q_dmem, 32'h0);

        // LEDS
        wr(32'h1001, 32'hFFFF_A5A5);
        chk("leds_port", {16'd0, leds}, 32'h0000_A5A5);
        rd(32'h1001);
        chk("leds_rd", q_dmem, 32'h0000_A5A5);

        // FIFO fill + overflow with consumer stalled
        tx_ready = 1'b0;
        wr(32'h1002, 32'd100);
        chk("txvalid_rise", {31'd0, tx_valid}, 32'h1);
        for (int i = 1; i < 9; i++) wr(32'h1002, 32'd100 + 32'(i));
        rd(32'h1003);
        chk("stat_full_ovf", q_dmem, 32'h0000_0046);
        wr(32'h1003, 32'h0);
        rd(32'h1003);
        chk("stat_ovf_clear", q_dmem, 32'h0000_0042);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'd0, tx_valid}, 32'h1);
            chk("drain_data", tx_data, 32'd100 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        chk("ninth_dropped", {31'd0, tx_valid}, 32'h0);
        rd(32'h1003);
        chk("stat_empty", q_dmem, 32'h0000_0001);

        // Push while full and popping on the same edge is accepted
        for (int i = 0; i < 8; i++) wr(32'h1002, 32'd200 + 32'(i));
        address_dmem = 32'h1002;
        data         = 32'd208;
        wren         = 1'b1;
        tx_ready     = 1'b1;
        chk("full_pop_head", tx_data, 32'd200);
        tick();
        wren     = 1'b0;
        tx_ready = 1'b0;
        rd(32'h1003);
        chk("stat_full_noovf", q_dmem, 32'h0000_0042);
        tx_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            chk("full_pop_order", tx_data, 32'd200 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        chk("full_pop_drained", {31'd0, tx_valid}, 32'h0);

        // Ordering and stability under random backpressure
        for (int i = 1; i <= 3; i++) begin
            wr(32'h1002, 32'(i));
            exp_q.push_back(32'(i));
        end
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (prev_stall) chk("tx_hold", tx_data, prev_data);
            if (tx_valid && tx_ready) chk("tx_order", tx_data, exp_q.pop_front());
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            tick();
        end
        tx_ready = 1'b0;
        chk("order_done", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation
        wr(32'h010, 32'hCAFE_F00D);
        wr(32'h1001, 32'h0000_A5A5);
        for (int i = 0; i < 4; i++) wr(32'h1002, 32'd50 + 32'(i));
        rd(32'h1003);
        chk("stat_count4", q_dmem, 32'h0000_0020);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_txvalid", {31'd0, tx_valid}, 32'h0);
        chk("midrst_leds", {16'd0, leds}, 32'h0);
        chk("midrst_q", q_dmem, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        rd(32'h010);
        chk("ram_survives_rst", q_dmem, 32'hCAFE_F00D);
        rd(32'h1003);
        chk("stat_after_rst", q_dmem, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have port clock, input, 1, the single master clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port address_dmem, input, 32, word address from the processor data-memory port.
REQ-004 SHALL have port data, input, 32, processor write data.
REQ-005 SHALL have port wren, input, 1, processor write enable.
REQ-006 SHALL have port q_dmem, output, 32, registered read data returned to the processor.
REQ-007 SHALL have port tx_data, output, 32, head entry of the transmit FIFO.
REQ-008 SHALL have port tx_valid, output, 1, high when the transmit FIFO is non-empty.
REQ-009 SHALL have port tx_ready, input, 1, downstream consumer accepts tx_data.
REQ-010 SHALL have port leds, output, 16, LED register contents.
REQ-011 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two).

Function
REQ-012 SHALL decode address_dmem as follows.
- 0x000-0x3FF: RAM, 1024 x 32, indexed by address_dmem[9:0].
- 0x1000: CYCLE, read-only.
- 0x1001: LEDS, read/write.
- 0x1002: TXDATA, write-only.
- 0x1003: TXSTAT, read; write clears overflow.
- All other addresses: reads return 0 and writes are ignored.
REQ-013 SHALL register q_dmem on each rising edge from the address presented before that edge, giving 1-cycle read latency; the value is pre-write (read-old) when a write to the same location occurs on that edge.
REQ-014 SHALL return the written value in the cycle following a RAM write when the same address is read.
REQ-015 SHALL increment CYCLE by 1 every clock, wrapping 0xFFFFFFFF to 0; a CYCLE read returns the pre-increment value; writes to CYCLE are ignored.
REQ-016 SHALL load leds from data[15:0] on a write to LEDS; a LEDS read returns {16'b0, leds}.
REQ-017 SHALL push data into the FIFO tail on a write to TXDATA when count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise it SHALL drop the data and set the sticky overflow bit.
REQ-018 SHALL pop the FIFO head on a rising edge where tx_valid and tx_ready are both high.
- tx_data SHALL be valid whenever tx_valid is high.
- tx_data SHALL hold stable while tx_valid is high and tx_ready is low.
REQ-019 SHALL leave count unchanged on a simultaneous push and pop; an empty FIFO with a push SHALL perform the push only, with no pop, and tx_valid SHALL rise the next cycle.
REQ-020 SHALL return TXSTAT read data as follows.
- bit0: empty.
- bit1: full.
- bit2: overflow.
- bits[6:3]: count (0..FIFO_DEPTH).
- All other bits: 0.
REQ-021 SHALL clear overflow on any write to TXSTAT; when a clear and a new overflow occur on the same edge, overflow SHALL end set.
REQ-022 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, using a separate count or an extra pointer bit to distinguish full from empty.
REQ-023 SHALL derive tx_valid from registered state only, with no combinational path from tx_ready to tx_valid.

Reset
REQ-024 SHALL, while reset is low, force q_dmem=0, CYCLE=0, leds=0, FIFO count=0, both pointers=0, overflow=0, and tx_valid=0, independent of clock.
REQ-025 SHALL leave RAM contents unaffected by reset.
REQ-026 SHALL discard FIFO contents when reset is asserted mid-transfer; tx_valid SHALL fall immediately.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts; CYCLE reads 0 on a read issued in that first cycle.

Verification
REQ-028 Bench SHALL cover a RAM write/read: write 0xDEADBEEF to 0x005, read 0x005 next cycle -> q_dmem=0xDEADBEEF one cycle later; read 0x800 -> 0.
REQ-029 Bench SHALL cover a CYCLE read: release reset, then read 0x1000 at cycles 0 and 10 -> values differ by 10; preload near 0xFFFFFFFF via a forced counter to confirm wrap to 0.
REQ-030 Bench SHALL cover FIFO fill and overflow: tx_ready=0, 9 writes to 0x1002 -> TXSTAT full=1, count=8, overflow=1; write 0x1003 -> overflow=0; 9th value is never emitted.
REQ-031 Bench SHALL cover FIFO ordering: push 1,2,3 with tx_ready toggling randomly -> handshakes emit 1,2,3 in order and tx_data is stable while stalled; push while full and popping is accepted.
REQ-032 Bench SHALL cover reset mid-operation: 4 entries queued, leds=0xA5A5, then assert reset -> tx_valid=0 and leds=0 immediately; a RAM word written before reset reads back unchanged.
